// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the issue logic and the branch resolution stage.
// The master side drives requests and result backpressure; the slave side is the resolver.
interface branch_resolve_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] link;
    logic            mispredict;
    logic            misalign;
    logic            illegal;

    modport master (
        output in_valid, is_branch, is_jal, is_jalr, funct3, pc, rs1, rs2, imm,
               pred_taken, pred_target, out_ready,
        input  in_ready, out_valid, taken, redirect_pc, link, mispredict, misalign, illegal
    );

    modport slave (
        input  in_valid, is_branch, is_jal, is_jalr, funct3, pc, rs1, rs2, imm,
               pred_taken, pred_target, out_ready,
        output in_ready, out_valid, taken, redirect_pc, link, mispredict, misalign, illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates the condition, target and mispredict for one
// control transfer per cycle, buffers results in a 2-entry skid buffer and counts completions.
module branch_resolve_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32,
    parameter int C_EXT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  cnt_clr,
    branch_resolve_unit_if.slave  bus,
    output logic [CNT_W-1:0]      cnt_branch,
    output logic [CNT_W-1:0]      cnt_mispred
);

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            misalign;
        logic            illegal;
        logic            is_branch;
        logic [XLEN-1:0] redirect;
        logic [XLEN-1:0] link;
    } entry_t;

    localparam logic [XLEN-1:0]  INSN_BYTES = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic            cond_s;
    logic            illegal_s;
    logic            taken_s;
    logic [XLEN-1:0] link_s;
    logic [XLEN-1:0] pc_target_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] target_s;
    entry_t          new_s;

    entry_t          r0_r;
    entry_t          r1_r;
    logic            r0_valid_r;
    logic            r1_valid_r;
    logic            in_fire_s;
    logic            out_fire_s;
    logic [CNT_W-1:0] cnt_branch_r;
    logic [CNT_W-1:0] cnt_mispred_r;

    // Condition evaluation for the six conditional branch encodings
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        case (bus.funct3)
            3'b000:  cond_s = (bus.rs1 == bus.rs2);
            3'b001:  cond_s = (bus.rs1 != bus.rs2);
            3'b100:  cond_s = ($signed(bus.rs1) <  $signed(bus.rs2));
            3'b101:  cond_s = ($signed(bus.rs1) >= $signed(bus.rs2));
            3'b110:  cond_s = (bus.rs1 <  bus.rs2);
            3'b111:  cond_s = (bus.rs1 >= bus.rs2);
            3'b010,
            3'b011:  illegal_s = bus.is_branch;
            default: cond_s = 1'b0;
        endcase
    end

    // Target, direction, link and prediction check for the incoming request
    always_comb begin
        pc_target_s = bus.pc + bus.imm;
        jalr_sum_s  = bus.rs1 + bus.imm;
        link_s      = bus.pc + INSN_BYTES;
        if (bus.is_jalr) begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = pc_target_s;
        end
        taken_s = bus.is_jal | bus.is_jalr | (bus.is_branch & cond_s & ~illegal_s);

        new_s            = '0;
        new_s.taken      = taken_s;
        new_s.illegal    = illegal_s;
        new_s.is_branch  = bus.is_branch;
        new_s.link       = link_s;
        new_s.redirect   = taken_s ? target_s : link_s;
        new_s.misalign   = taken_s && ((C_EXT != 0) ? 1'b0 : target_s[1]);
        new_s.mispredict = (taken_s != bus.pred_taken) ||
                           (taken_s && (target_s != bus.pred_target));
    end

    assign in_fire_s    = bus.in_valid & bus.in_ready;
    assign out_fire_s   = r0_valid_r & bus.out_ready;
    assign bus.in_ready = ~reset & ~r1_valid_r;

    // Skid buffer: R0 drives the outputs, R1 absorbs one request while R0 is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_valid_r <= 1'b0;
            r1_valid_r <= 1'b0;
            r0_r       <= '0;
            r1_r       <= '0;
        end else if (flush) begin
            r0_valid_r <= 1'b0;
            r1_valid_r <= 1'b0;
        end else if (r1_valid_r) begin
            if (out_fire_s) begin
                r0_r       <= r1_r;
                r1_valid_r <= 1'b0;
            end else begin
                r1_valid_r <= 1'b1;
            end
        end else if (in_fire_s) begin
            if (!r0_valid_r || out_fire_s) begin
                r0_r       <= new_s;
                r0_valid_r <= 1'b1;
            end else begin
                r1_r       <= new_s;
                r1_valid_r <= 1'b1;
            end
        end else if (out_fire_s) begin
            r0_valid_r <= 1'b0;
        end else begin
            r0_valid_r <= r0_valid_r;
        end
    end

    // Saturating perf counters; a consumed entry counts even when flushed in the same cycle
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            cnt_branch_r  <= '0;
            cnt_mispred_r <= '0;
        end else if (out_fire_s) begin
            if (r0_r.is_branch && !(&cnt_branch_r)) begin
                cnt_branch_r <= cnt_branch_r + CNT_ONE;
            end else begin
                cnt_branch_r <= cnt_branch_r;
            end
            if (r0_r.mispredict && !(&cnt_mispred_r)) begin
                cnt_mispred_r <= cnt_mispred_r + CNT_ONE;
            end else begin
                cnt_mispred_r <= cnt_mispred_r;
            end
        end else begin
            cnt_branch_r  <= cnt_branch_r;
            cnt_mispred_r <= cnt_mispred_r;
        end
    end

    assign bus.out_valid   = r0_valid_r;
    assign bus.taken       = r0_r.taken;
    assign bus.redirect_pc = r0_r.redirect;
    assign bus.link        = r0_r.link;
    assign bus.mispredict  = r0_r.mispredict;
    assign bus.misalign    = r0_r.misalign;
    assign bus.illegal     = r0_r.illegal;
    assign cnt_branch      = cnt_branch_r;
    assign cnt_mispred     = cnt_mispred_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: dut0 (C_EXT=0, 4-bit counters) and dut1 (C_EXT=1,
// 32-bit counters) see identical stimulus; expected values are hand-computed constants.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    logic reset, flush, cnt_clr;
    logic [3:0]  cb0, cm0;
    logic [31:0] cb1, cm1;
    int tests = 0;
    int fails = 0;

    branch_resolve_unit_if #(.XLEN(64)) bus0 ();
    branch_resolve_unit_if #(.XLEN(64)) bus1 ();

    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.is_branch   = bus0.is_branch;
    assign bus1.is_jal      = bus0.is_jal;
    assign bus1.is_jalr     = bus0.is_jalr;
    assign bus1.funct3      = bus0.funct3;
    assign bus1.pc          = bus0.pc;
    assign bus1.rs1         = bus0.rs1;
    assign bus1.rs2         = bus0.rs2;
    assign bus1.imm         = bus0.imm;
    assign bus1.pred_taken  = bus0.pred_taken;
    assign bus1.pred_target = bus0.pred_target;
    assign bus1.out_ready   = bus0.out_ready;

    branch_resolve_unit #(.XLEN(64), .CNT_W(4), .C_EXT(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .cnt_clr(cnt_clr),
        .bus(bus0), .cnt_branch(cb0), .cnt_mispred(cm0)
    );

    branch_resolve_unit #(.XLEN(64), .CNT_W(32), .C_EXT(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .cnt_clr(cnt_clr),
        .bus(bus1), .cnt_branch(cb1), .cnt_mispred(cm1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic pt, input logic [63:0] ptgt);
        bus0.in_valid    = 1'b1;
        bus0.is_branch   = b;
        bus0.is_jal      = j;
        bus0.is_jalr     = jr;
        bus0.funct3      = f3;
        bus0.pc          = pc;
        bus0.rs1         = rs1;
        bus0.rs2         = rs2;
        bus0.imm         = imm;
        bus0.pred_taken  = pt;
        bus0.pred_target = ptgt;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        bus0.out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
        bus0.in_valid = 1'b0;
        step(); step();
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
        chk("rst_redirect", bus0.redirect_pc, 64'd0);
        chk("rst_cnt_branch", 64'(cb0), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus0.in_ready), 64'd1);

        // BGE equal operands, predicted not taken
        drive(1'b1, 1'b0, 1'b0, 3'b101, 64'h1000, 64'd5, 64'd5, 64'h20, 1'b0, 64'd0);
        step();
        chk("bge_valid", 64'(bus0.out_valid), 64'd1);
        chk("bge_taken", 64'(bus0.taken), 64'd1);
        chk("bge_redirect", bus0.redirect_pc, 64'h1020);
        chk("bge_link", bus0.link, 64'h1004);
        chk("bge_mispred", 64'(bus0.mispredict), 64'd1);
        bus0.in_valid = 1'b0;
        step();
        chk("bge_cnt_branch", 64'(cb0), 64'd1);
        chk("bge_cnt_mispred", 64'(cm0), 64'd1);
        chk("bge_drained", 64'(bus0.out_valid), 64'd0);

        // BLT signed vs BLTU on -1 / 1, back to back
        drive(1'b1, 1'b0, 1'b0, 3'b100, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 1'b1, 64'h140);
        step();
        chk("blt_taken", 64'(bus0.taken), 64'd1);
        chk("blt_redirect", bus0.redirect_pc, 64'h140);
        chk("blt_mispred", 64'(bus0.mispredict), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b110, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 1'b1, 64'h140);
        step();
        chk("bltu_taken", 64'(bus0.taken), 64'd0);
        chk("bltu_redirect", bus0.redirect_pc, 64'h104);
        chk("bltu_mispred", 64'(bus0.mispredict), 64'd1);

        // JALR with odd base: bit0 cleared, bit1 set
        drive(1'b0, 1'b0, 1'b1, 3'd0, 64'h400, 64'h2003, 64'd0, 64'd0, 1'b1, 64'h2002);
        step();
        chk("jalr_redirect", bus0.redirect_pc, 64'h2002);
        chk("jalr_link", bus0.link, 64'h404);
        chk("jalr_misalign_c0", 64'(bus0.misalign), 64'd1);
        chk("jalr_misalign_c1", 64'(bus1.misalign), 64'd0);
        chk("jalr_mispred", 64'(bus0.mispredict), 64'd0);
        chk("jalr_cnt_branch", 64'(cb0), 64'd3);

        // Address wrap and illegal funct3
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 64'd7, 64'd8, 1'b1, 64'h4);
        step();
        chk("wrap_redirect", bus0.redirect_pc, 64'h4);
        chk("wrap_mispred", 64'(bus0.mispredict), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 64'd7, 64'd8, 1'b0, 64'h0);
        step();
        chk("ill_illegal", 64'(bus0.illegal), 64'd1);
        chk("ill_taken", 64'(bus0.taken), 64'd0);
        chk("ill_redirect", bus0.redirect_pc, 64'd0);

        // JAL backwards with wrong predicted target
        drive(1'b0, 1'b1, 1'b0, 3'd0, 64'h200, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'h1FC);
        step();
        chk("jal_redirect", bus0.redirect_pc, 64'h1F8);
        chk("jal_mispred", 64'(bus0.mispredict), 64'd1);
        bus0.in_valid = 1'b0;
        step();
        chk("mid_cnt_branch", 64'(cb0), 64'd5);
        chk("mid_cnt_mispred", 64'(cm0), 64'd3);

        // Backpressure: three requests while the consumer stalls
        bus0.out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h10, 64'd0, 64'd0, 64'h100, 1'b1, 64'h110);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h20, 64'd0, 64'd0, 64'h100, 1'b1, 64'h120);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h30, 64'd0, 64'd0, 64'h100, 1'b1, 64'h130);
        chk("bp_in_ready_full", 64'(bus0.in_ready), 64'd0);
        chk("bp_hold_a", bus0.redirect_pc, 64'h110);
        step();
        chk("bp_stable_a", bus0.redirect_pc, 64'h110);
        chk("bp_stable_valid", 64'(bus0.out_valid), 64'd1);
        bus0.out_ready = 1'b1;
        step();
        chk("bp_second_b", bus0.redirect_pc, 64'h120);
        chk("bp_in_ready_free", 64'(bus0.in_ready), 64'd1);
        step();
        chk("bp_third_c", bus0.redirect_pc, 64'h130);
        bus0.in_valid = 1'b0;
        step();
        chk("bp_drained", 64'(bus0.out_valid), 64'd0);
        chk("bp_cnt_branch", 64'(cb0), 64'd8);

        // Flush with both entries full, then flush discarding a same-cycle accept
        bus0.out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h40, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
        step();
        step();
        bus0.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus0.in_ready), 64'd1);
        chk("flush_cnt_mispred", 64'(cm0), 64'd3);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h50, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus0.in_valid = 1'b0;
        chk("flush_accept_drop", 64'(bus0.out_valid), 64'd0);
        bus0.out_ready = 1'b1;

        // Saturation of the 4-bit counters
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h1000 + 64'(i) * 64'd4, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
            step();
        end
        bus0.in_valid = 1'b0;
        step();
        chk("sat_cnt_branch", 64'(cb0), 64'hF);
        chk("sat_cnt_mispred", 64'(cm0), 64'hF);
        chk("wide_cnt_branch", 64'(cb1), 64'd20);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h2000, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
        step();
        bus0.in_valid = 1'b0;
        step();
        chk("sat_hold_mispred", 64'(cm0), 64'hF);
        chk("wide_cnt_mispred", 64'(cm1), 64'd16);

        // Clear wins over a same-cycle increment
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h3000, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
        step();
        bus0.in_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cnt_mispred", 64'(cm0), 64'd0);
        chk("clr_cnt_branch_wide", 64'(cb1), 64'd0);

        // Flush in the same cycle as a consume still counts that entry
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h3100, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
        step();
        bus0.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flushfire_cnt_branch", 64'(cb0), 64'd1);
        chk("flushfire_cnt_mispred", 64'(cm0), 64'd1);

        // Reset in the middle of a stalled transfer
        bus0.out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h3200, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
        step();
        reset = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        chk("rst2_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst2_in_ready", 64'(bus0.in_ready), 64'd0);
        chk("rst2_redirect", bus0.redirect_pc, 64'd0);
        chk("rst2_cnt_branch", 64'(cb0), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst2_in_ready_back", 64'(bus0.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
